// File: rtl/lab4_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab4_display_pkg
// Description : Shared types and constants for the lab4 seven-segment
//               display scanner. Provides the hex digit and segment types,
//               the all-off patterns for the common-anode display, and the
//               active-low hex-to-segment table.
// Contents    : digit_t, seg_t, SEG_BLANK, AN_OFF, SEG_TABLE
// Revision    : 1.0 - initial release
// ============================================================================
package lab4_display_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    // Everything active-low, so all ones means dark.
    localparam seg_t       SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Bit order is g..a (bit 6 = g, bit 0 = a); a 0 lights the segment.
    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage : lab4_display_pkg
`default_nettype wire

// File: rtl/hex_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seven_seg
// Description : Combinational hex nibble to active-low seven-segment decode.
// Ports       : i_digit - 4-bit hex code
//               o_seg   - segments g..a, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seven_seg
    import lab4_display_pkg::*;
(
    input  digit_t i_digit,
    output seg_t   o_seg
);

    assign o_seg = SEG_TABLE[i_digit];

endmodule : hex_to_seven_seg
`default_nettype wire

// File: rtl/lab4_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : lab4_display_scanner
// Description : Time-multiplexes four hex digits onto a 4-digit common-anode
//               seven-segment display. Each digit slot starts with a blanking
//               interval, leading zeros can be suppressed, and new values are
//               double-buffered so they only take effect at a frame boundary.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-high reset
//               display_on - 0 darkens the display, scanning continues
//               lz_blank   - 1 suppresses leading zeros on digits 3..1
//               upd_valid  - producer offers upd_data
//               upd_data   - digit3..digit0 in [15:12]..[3:0]
//               upd_ready  - shadow buffer free
//               frame_done - one-cycle pulse at each frame wrap
//               an         - anode enables, active-low, an[0] rightmost
//               cathode    - segments g..a, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module lab4_display_scanner
    import lab4_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        display_on,
    input  logic        lz_blank,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [6:0]  cathode
);

    localparam int                 c_CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(BLANK_CYCLES);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_digit;
    logic [15:0]        r_active;
    logic [15:0]        r_shadow;
    logic               r_pending;
    logic               r_frame_done;
    logic [3:0]         r_an;
    logic [6:0]         r_cathode;

    logic               w_slot_end;
    logic               w_frame_wrap;
    logic               w_xfer;
    logic               w_load;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [1:0]         w_digit_nxt;
    logic [15:0]        w_active_nxt;
    logic [0:0]         w_state_nxt;
    digit_t             w_nibble;
    seg_t               w_seg;
    logic [3:0]         w_lz_mask;
    logic               w_suppress;
    logic [3:0]         w_an_nxt;
    logic [6:0]         w_cathode_nxt;

    // ------------------------------------------------------------------
    // Next-state values. The output registers are loaded from these so
    // that an/cathode always correspond to the cnt/digit currently held.
    // ------------------------------------------------------------------
    assign w_slot_end   = (r_cnt == c_CNT_MAX);
    assign w_frame_wrap = w_slot_end && (r_digit == 2'd3);
    assign w_xfer       = upd_valid && !r_pending;
    // Only a value already sitting in the shadow moves to active; a
    // transfer landing on the wrap edge waits for the following wrap.
    assign w_load       = w_frame_wrap && r_pending;

    assign w_cnt_nxt    = w_slot_end ? '0 : r_cnt + 1'b1;
    assign w_digit_nxt  = w_slot_end ? r_digit + 2'd1 : r_digit;
    assign w_active_nxt = w_load ? r_shadow : r_active;
    assign w_state_nxt  = (w_cnt_nxt < c_BLANK_END) ? c_ST_BLANK : c_ST_SHOW;

    always_comb begin
        w_nibble = w_active_nxt[3:0];
        case (w_digit_nxt)
            2'd0:    w_nibble = w_active_nxt[3:0];
            2'd1:    w_nibble = w_active_nxt[7:4];
            2'd2:    w_nibble = w_active_nxt[11:8];
            default: w_nibble = w_active_nxt[15:12];
        endcase
    end

    hex_to_seven_seg u_decode (
        .i_digit (w_nibble),
        .o_seg   (w_seg)
    );

    // A digit is a leading zero when it and every digit above it is zero.
    // Digit 0 always lights so a zero value still reads "0".
    assign w_lz_mask[3] = (w_active_nxt[15:12] == 4'h0);
    assign w_lz_mask[2] = w_lz_mask[3] && (w_active_nxt[11:8] == 4'h0);
    assign w_lz_mask[1] = w_lz_mask[2] && (w_active_nxt[7:4] == 4'h0);
    assign w_lz_mask[0] = 1'b0;

    assign w_suppress = lz_blank && w_lz_mask[w_digit_nxt];

    always_comb begin
        w_an_nxt      = AN_OFF;
        w_cathode_nxt = SEG_BLANK;
        if (display_on && (w_state_nxt == c_ST_SHOW) && !w_suppress) begin
            w_an_nxt      = ~(4'b0001 << w_digit_nxt);
            w_cathode_nxt = w_seg;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_digit      <= 2'd0;
            r_active     <= 16'h0000;
            r_shadow     <= 16'h0000;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_an         <= AN_OFF;
            r_cathode    <= SEG_BLANK;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_digit      <= w_digit_nxt;
            r_active     <= w_active_nxt;
            r_frame_done <= w_frame_wrap;
            r_an         <= w_an_nxt;
            r_cathode    <= w_cathode_nxt;
            // w_xfer needs pending=0 and w_load needs pending=1, so at
            // most one of these fires on any edge.
            if (w_xfer) begin
                r_shadow  <= upd_data;
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign upd_ready  = !r_pending;
    assign frame_done = r_frame_done;
    assign an         = r_an;
    assign cathode    = r_cathode;

endmodule : lab4_display_scanner
`default_nettype wire
